// File: rtl/pio_edge_irq_multi.sv
// Avalon-MM PIO input slave: synchronised, debounced WIDTH-bit input bus with
// per-bit rise/fall edge capture (write-1-to-clear), interrupt mask and level irq.
module pio_edge_irq_multi #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_RISE    = 3'd4;
    localparam logic [2:0] ADDR_FALL    = 3'd5;
    localparam logic [2:0] ADDR_THR     = 3'd6;
    localparam logic [2:0] ADDR_PENDING = 3'd7;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  s;
    logic [WIDTH-1:0]                  q;
    logic [WIDTH-1:0]                  q_nxt;
    logic [WIDTH-1:0]                  q_d;
    logic [WIDTH-1:0][DEBOUNCE_W-1:0]  cnt;
    logic [WIDTH-1:0][DEBOUNCE_W-1:0]  cnt_nxt;

    logic [WIDTH-1:0]      irq_mask;
    logic [WIDTH-1:0]      edge_capture;
    logic [WIDTH-1:0]      rise_en;
    logic [WIDTH-1:0]      fall_en;
    logic [DEBOUNCE_W-1:0] debounce_thr;

    logic                  wr_en;
    logic [WIDTH-1:0]      wr_bits;
    logic [WIDTH-1:0]      rise;
    logic [WIDTH-1:0]      fall;
    logic [WIDTH-1:0]      ev;
    logic [WIDTH-1:0]      clr_bits;
    logic [WIDTH-1:0]      capture_nxt;
    logic [WIDTH-1:0]      mask_nxt;
    logic [DATA_W-1:0]     rdata_c;
    logic                  unused_wdata;

    assign wr_en   = chipselect & ~write_n;
    assign wr_bits = writedata[WIDTH-1:0];
    // Bits above WIDTH / DEBOUNCE_W are deliberately ignored on writes.
    assign unused_wdata = ^writedata;

    // Input synchroniser chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce: a change must survive debounce_thr+1 samples; cnt never exceeds thr
    always_comb begin
        q_nxt   = q;
        cnt_nxt = cnt;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (s[i] == q[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] >= debounce_thr) begin
                q_nxt[i]   = s[i];
                cnt_nxt[i] = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + DEBOUNCE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q   <= '0;
            q_d <= '0;
            cnt <= '0;
        end else begin
            q   <= q_nxt;
            q_d <= q;
            cnt <= cnt_nxt;
        end
    end

    assign rise = q & ~q_d;
    assign fall = ~q & q_d;
    assign ev   = (rise & rise_en) | (fall & fall_en);

    // New events override a simultaneous clear so no edge is lost
    assign clr_bits    = (wr_en && (address == ADDR_CAPTURE)) ? wr_bits : '0;
    assign capture_nxt = (edge_capture & ~clr_bits) | ev;
    assign mask_nxt    = (wr_en && (address == ADDR_MASK)) ? wr_bits : irq_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
            rise_en      <= '0;
            fall_en      <= '1;
            debounce_thr <= '0;
        end else begin
            irq_mask     <= mask_nxt;
            edge_capture <= capture_nxt;
            if (wr_en && (address == ADDR_RISE)) begin
                rise_en <= wr_bits;
            end
            if (wr_en && (address == ADDR_FALL)) begin
                fall_en <= wr_bits;
            end
            if (wr_en && (address == ADDR_THR)) begin
                debounce_thr <= writedata[DEBOUNCE_W-1:0];
            end
        end
    end

    // Read mux; registered every cycle regardless of chipselect
    always_comb begin
        rdata_c = '0;
        case (address)
            ADDR_DATA:    rdata_c = DATA_W'(q);
            ADDR_MASK:    rdata_c = DATA_W'(irq_mask);
            ADDR_CAPTURE: rdata_c = DATA_W'(edge_capture);
            ADDR_RISE:    rdata_c = DATA_W'(rise_en);
            ADDR_FALL:    rdata_c = DATA_W'(fall_en);
            ADDR_THR:     rdata_c = DATA_W'(debounce_thr);
            ADDR_PENDING: rdata_c = DATA_W'(edge_capture & irq_mask);
            default:      rdata_c = '0;
        endcase
    end

    // irq registered from next-state values so it tracks capture/mask on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rdata_c;
            irq      <= |(capture_nxt & mask_nxt);
        end
    end

endmodule
